// File: rtl/multi_clock_divider_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
// Used by: multi_clock_divider, clkdiv_channel, multi_clock_divider_if.
package clkdiv_pkg;

    // Prescaler ratio: clk cycles per base tick.
    function automatic int unsigned calc_div(
        input int unsigned clk_hz,
        input int unsigned base_hz
    );
        return clk_hz / base_hz;
    endfunction

    // DIV at the default 50 MHz / 1 kHz configuration.
    localparam int unsigned DIV = calc_div(50_000_000, 1000);

    // Index width for n items, never less than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

    // ceil(p/2) computed one bit wider than p so the
    // all-ones period cannot wrap.
    function automatic logic [32:0] half_period(input logic [31:0] p);
        return ({1'b0, p} + 33'd1) >> 1;
    endfunction

endpackage

// File: rtl/multi_clock_divider_if.sv
// Bus between the divider and its controller.
// master: drives en/wr_en/wr_ch/wr_period (+sync when
// MULTI_CLOCK_DIVIDER_SYNC_EN is defined) and reads ld/tick/base_tick.
// slave: the divider side of the same bundle.
interface multi_clock_divider_if #(
    parameter int unsigned NCH = 4,
    parameter int unsigned PW  = 16
);
    import clkdiv_pkg::*;

    localparam int unsigned CW = idx_width(NCH);

    logic [NCH-1:0] en;
    logic           wr_en;
    logic [CW-1:0]  wr_ch;
    logic [PW-1:0]  wr_period;
    logic [NCH-1:0] ld;
    logic [NCH-1:0] tick;
    logic           base_tick;
`ifdef MULTI_CLOCK_DIVIDER_SYNC_EN
    logic           sync;
`endif

    modport master (
        output en, wr_en, wr_ch, wr_period,
`ifdef MULTI_CLOCK_DIVIDER_SYNC_EN
        output sync,
`endif
        input  ld, tick, base_tick
    );

    modport slave (
        input  en, wr_en, wr_ch, wr_period,
`ifdef MULTI_CLOCK_DIVIDER_SYNC_EN
        input  sync,
`endif
        output ld, tick, base_tick
    );

endinterface

// File: rtl/multi_clock_divider_channel.sv
// One divider channel: phase counter, active/pending period and
// registered ld (square wave) / tick (wrap strobe) outputs.
// Ports: clk, rst (sync, active-high), en, base_tick, sync,
// wr (write strobe for this channel), wr_period, ld, tick.
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int unsigned PW             = 16,
    parameter int unsigned DEFAULT_PERIOD = 1000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          base_tick,
    input  logic          sync,
    input  logic          wr,
    input  logic [PW-1:0] wr_period,
    output logic          ld,
    output logic          tick
);

    logic [PW-1:0] cnt;
    logic [PW-1:0] active;
    logic [PW-1:0] pending;
    logic          pend_q;

    logic          running;
    logic          at_wrap;
    logic [PW:0]   half;

    assign running = en && (active != '0);
    assign at_wrap = (cnt == active - PW'(1));
    assign half    = (PW+1)'(half_period(32'(active)));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            active  <= PW'(DEFAULT_PERIOD);
            pending <= PW'(DEFAULT_PERIOD);
            pend_q  <= 1'b0;
            ld      <= 1'b0;
            tick    <= 1'b0;
        end else begin
            // ld follows the pre-edge phase, one clk behind cnt
            ld   <= running && ({1'b0, cnt} < half);
            tick <= 1'b0;

            if (!running) begin
                cnt <= '0;
            end else if (base_tick && !sync) begin
                if (at_wrap) begin
                    cnt  <= '0;
                    tick <= 1'b1;
                    // period swaps only at a wrap so ld never glitches
                    if (pend_q) begin
                        active <= pending;
                        pend_q <= 1'b0;
                    end
                end else begin
                    cnt <= cnt + PW'(1);
                end
            end

            if (sync) begin
                cnt <= '0;
                if (pend_q) begin
                    active <= pending;
                    pend_q <= 1'b0;
                end
            end

            // later assignments win: a write in a wrap cycle
            // re-arms pending for the following wrap
            if (wr) begin
                if (!running) begin
                    active <= wr_period;
                    cnt    <= '0;
                    pend_q <= 1'b0;
                end else begin
                    pending <= wr_period;
                    pend_q  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/multi_clock_divider.sv
// Shared BASE_HZ prescaler feeding NCH programmable divider channels.
// Ports: clk, rst (sync, active-high), bus (slave modport:
// en, wr_en, wr_ch, wr_period in; ld, tick, base_tick out).
// Optional MULTI_CLOCK_DIVIDER_SYNC_EN adds bus.sync to realign phases.
module multi_clock_divider
    import clkdiv_pkg::*;
#(
    parameter int unsigned CLK_HZ         = 50_000_000,
    parameter int unsigned BASE_HZ        = 1000,
    parameter int unsigned NCH            = 4,
    parameter int unsigned PW             = 16,
    parameter int unsigned DEFAULT_PERIOD = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    multi_clock_divider_if.slave  bus
);

    localparam int unsigned DIV_R = calc_div(CLK_HZ, BASE_HZ);
    localparam int unsigned PSW   = idx_width(DIV_R);
    localparam int unsigned CW    = idx_width(NCH);

    logic [PSW-1:0] pre;
    logic           base_tick_q;
    logic           sync_s;
    logic [NCH-1:0] wr_hit;
    logic [NCH-1:0] ld_v;
    logic [NCH-1:0] tick_v;

`ifdef MULTI_CLOCK_DIVIDER_SYNC_EN
    assign sync_s = bus.sync;
`else
    assign sync_s = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pre         <= '0;
            base_tick_q <= 1'b0;
        end else if (sync_s) begin
            pre         <= '0;
            base_tick_q <= 1'b0;
        end else if (pre == PSW'(DIV_R - 1)) begin
            pre         <= '0;
            base_tick_q <= 1'b1;
        end else begin
            pre         <= pre + PSW'(1);
            base_tick_q <= 1'b0;
        end
    end

    // out-of-range wr_ch matches no channel and is dropped
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign wr_hit[i] = bus.wr_en && (bus.wr_ch == CW'(i));

        clkdiv_channel #(
            .PW             (PW),
            .DEFAULT_PERIOD (DEFAULT_PERIOD)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .en        (bus.en[i]),
            .base_tick (base_tick_q),
            .sync      (sync_s),
            .wr        (wr_hit[i]),
            .wr_period (bus.wr_period),
            .ld        (ld_v[i]),
            .tick      (tick_v[i])
        );
    end

    assign bus.ld        = ld_v;
    assign bus.tick      = tick_v;
    assign bus.base_tick = base_tick_q;

endmodule
